// File: rtl/pkt_stim_pkg.sv
// Shared types and constants for the packet stimulus generator.
// Consumers: pkt_stim_gen and pkt_stim_lfsr.
package pkt_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [7:0]  HDR_MARK  = 8'hA5;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Header word layout: marker byte followed by the packet length in words.
    function automatic logic [15:0] hdr_word(input logic [7:0] len);
        return {HDR_MARK, len};
    endfunction

endpackage

// File: rtl/pkt_stim_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with advance-enable.
// Used as the payload source when PKT_STIM_LFSR_EN is defined.
module pkt_stim_lfsr
    import pkt_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] value,
    output logic [15:0] next_value
);

    // Feedback taps enter at the MSB while the register shifts right.
    assign next_value = {value[0] ^ value[2] ^ value[3] ^ value[5], value[15:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/pkt_stim_gen.sv
// Packet stimulus generator: header + payload words under valid/ready, rotating length/prio.
// Optional build macro PKT_STIM_LFSR_EN selects an LFSR payload instead of a word counter.
module pkt_stim_gen
    import pkt_stim_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 8,
    parameter int MIN_LEN = 2,
    parameter int MAX_LEN = 8,
    parameter int IPG     = 1
) (
    input  logic                                          sys_clk,
    input  logic                                          sys_rst,
    input  logic                                          enable,
    input  logic                                          ready,
    output logic                                          wr_vld,
    output logic                                          wr_sop,
    output logic                                          wr_eop,
    output logic [DATA_W-1:0]                             wr_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_prio,
    output logic [15:0]                                   pkt_cnt,
    output logic                                          busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W = (IPG > 1) ? $clog2(IPG) : 1;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_HDR  = ST_HDR;
    localparam logic [1:0] S_PAY  = ST_PAY;
    localparam logic [1:0] S_GAP  = ST_GAP;

    // Handshake: a word transfers on any edge where wr_vld & ready; while
    // wr_vld & !ready every word output holds until that transfer happens.
    logic [1:0]        state;
    logic [7:0]        len;
    logic [7:0]        rem;
    logic [GAP_W-1:0]  gap_cnt;
    logic [7:0]        len_nx;
    logic [CH_W-1:0]   prio_nx;
    logic [DATA_W-1:0] pay_cur;
    logic [DATA_W-1:0] pay_nxt;
    logic              accept;
    logic              pay_adv;

    assign accept  = wr_vld & ready;
    assign pay_adv = (state == S_PAY) & accept;
    assign len_nx  = (len == 8'(MAX_LEN)) ? 8'(MIN_LEN) : len + 8'd1;
    assign prio_nx = (wr_prio == CH_W'(NUM_CH - 1)) ? '0 : wr_prio + CH_W'(1);
    assign busy    = (state != S_IDLE);

`ifdef PKT_STIM_LFSR_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nx;

    pkt_stim_lfsr u_lfsr (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .advance    (pay_adv),
        .value      (lfsr_q),
        .next_value (lfsr_nx)
    );

    assign pay_cur = DATA_W'(lfsr_q);
    assign pay_nxt = DATA_W'(lfsr_nx);
`else
    logic [DATA_W-1:0] pay_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pay_q <= '0;
        end else if (pay_adv) begin
            pay_q <= pay_q + DATA_W'(1);
        end
    end

    assign pay_cur = pay_q;
    assign pay_nxt = pay_q + DATA_W'(1);
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= S_IDLE;
            len     <= 8'(MIN_LEN);
            rem     <= '0;
            gap_cnt <= '0;
            wr_vld  <= 1'b0;
            wr_sop  <= 1'b0;
            wr_eop  <= 1'b0;
            wr_data <= '0;
            wr_prio <= '0;
            pkt_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state   <= S_HDR;
                        wr_vld  <= 1'b1;
                        wr_sop  <= 1'b1;
                        wr_eop  <= 1'b0;
                        wr_data <= DATA_W'(hdr_word(len));
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        state   <= S_PAY;
                        wr_sop  <= 1'b0;
                        wr_data <= pay_cur;
                        wr_eop  <= (len == 8'd2);
                        rem     <= len - 8'd1;
                    end
                end
                S_PAY: begin
                    if (accept) begin
                        if (wr_eop) begin
                            // Packet done: rotate length and tag for the next one.
                            pkt_cnt <= pkt_cnt + 16'd1;
                            len     <= len_nx;
                            wr_prio <= prio_nx;
                            wr_eop  <= 1'b0;
                            if (IPG > 0) begin
                                state   <= S_GAP;
                                wr_vld  <= 1'b0;
                                gap_cnt <= GAP_W'(IPG - 1);
                            end else if (enable) begin
                                state   <= S_HDR;
                                wr_sop  <= 1'b1;
                                wr_data <= DATA_W'(hdr_word(len_nx));
                            end else begin
                                state  <= S_IDLE;
                                wr_vld <= 1'b0;
                            end
                        end else begin
                            wr_data <= pay_nxt;
                            wr_eop  <= (rem == 8'd2);
                            rem     <= rem - 8'd1;
                        end
                    end
                end
                default: begin
                    if (gap_cnt == '0) begin
                        if (enable) begin
                            state   <= S_HDR;
                            wr_vld  <= 1'b1;
                            wr_sop  <= 1'b1;
                            wr_data <= DATA_W'(hdr_word(len));
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_stim_gen.sv
// Self-checking bench for pkt_stim_gen: packet-level reference model + expected word queue.
// Build with +define+PKT_STIM_LFSR_EN to check the LFSR payload variant.
module tb_pkt_stim_gen;

    localparam int DATA_W  = 16;
    localparam int NUM_CH  = 4;
    localparam int MIN_LEN = 2;
    localparam int MAX_LEN = 4;
    localparam int IPG     = 1;
    localparam int CH_W    = 2;

`ifdef PKT_STIM_LFSR_EN
    localparam logic [DATA_W-1:0] FIRST_PAY = 16'hACE1;
`else
    localparam logic [DATA_W-1:0] FIRST_PAY = 16'h0000;
`endif

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              enable;
    logic              ready;
    logic              wr_vld;
    logic              wr_sop;
    logic              wr_eop;
    logic [DATA_W-1:0] wr_data;
    logic [CH_W-1:0]   wr_prio;
    logic [15:0]       pkt_cnt;
    logic              busy;

    pkt_stim_gen #(
        .DATA_W  (DATA_W),
        .NUM_CH  (NUM_CH),
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN),
        .IPG     (IPG)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .enable  (enable),
        .ready   (ready),
        .wr_vld  (wr_vld),
        .wr_sop  (wr_sop),
        .wr_eop  (wr_eop),
        .wr_data (wr_data),
        .wr_prio (wr_prio),
        .pkt_cnt (pkt_cnt),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [CH_W-1:0]   prio;
        logic [DATA_W-1:0] data;
        logic [7:0]        idx;
    } word_t;

    word_t exp_q[$];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_len;
    logic [CH_W-1:0] m_prio;
    logic [DATA_W-1:0] m_pay;
    logic [15:0] m_done;
    int          idle_run;
    logic        check_gap;
    logic        saw_eop;

    function automatic logic [DATA_W-1:0] pay_step(input logic [DATA_W-1:0] v);
`ifdef PKT_STIM_LFSR_EN
        logic [15:0] s;
        s = v[15:0];
        return DATA_W'({s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]});
`else
        return v + DATA_W'(1);
`endif
    endfunction

    task automatic model_reset();
        m_len  = 8'(MIN_LEN);
        m_prio = '0;
        m_pay  = FIRST_PAY;
        m_done = '0;
        exp_q.delete();
        idle_run  = 0;
        check_gap = 1'b0;
        saw_eop   = 1'b0;
    endtask

    // Expand the next packet into its expected words, then rotate length and tag.
    task automatic gen_packet();
        word_t w;
        for (int i = 0; i < int'(m_len); i++) begin
            w.sop  = (i == 0);
            w.eop  = (i == int'(m_len) - 1);
            w.prio = m_prio;
            w.idx  = 8'(i);
            if (i == 0) begin
                w.data = DATA_W'({8'hA5, m_len});
            end else begin
                w.data = m_pay;
                m_pay  = pay_step(m_pay);
            end
            exp_q.push_back(w);
        end
        m_len  = (m_len == 8'(MAX_LEN)) ? 8'(MIN_LEN) : m_len + 8'd1;
        m_prio = (m_prio == CH_W'(NUM_CH - 1)) ? '0 : m_prio + CH_W'(1);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One clock: drive ready, check the presented word against the queue head, advance.
    task automatic drive_cycle(input logic rdy);
        word_t h;
        ready = rdy;
        checks++;
        if (pkt_cnt !== m_done) begin
            errors++;
            $display("FAIL pkt_cnt: got %0d expected %0d", pkt_cnt, m_done);
        end
        if (wr_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                gen_packet();
                if (check_gap) begin
                    checks++;
                    if (idle_run != IPG) begin
                        errors++;
                        $display("FAIL gap_len: got %0d idle cycles expected %0d", idle_run, IPG);
                    end
                end
                check_gap = 1'b0;
            end
            h = exp_q[0];
            checks++;
            if ({wr_sop, wr_eop, wr_prio, wr_data} !== {h.sop, h.eop, h.prio, h.data}) begin
                errors++;
                $display("FAIL word: got sop=%0b eop=%0b prio=%0d data=%h expected sop=%0b eop=%0b prio=%0d data=%h",
                         wr_sop, wr_eop, wr_prio, wr_data, h.sop, h.eop, h.prio, h.data);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_vld: got %0b expected 1", busy);
            end
            if (rdy) begin
                void'(exp_q.pop_front());
                if (h.eop) begin
                    m_done++;
                    idle_run  = 0;
                    check_gap = enable;
                    saw_eop   = 1'b1;
                end
            end
        end else begin
            idle_run++;
        end
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({wr_vld, wr_sop, wr_eop, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_flags: got vld=%0b sop=%0b eop=%0b busy=%0b expected all 0",
                     tag, wr_vld, wr_sop, wr_eop, busy);
        end
        checks++;
        if (wr_data !== '0) begin
            errors++;
            $display("FAIL %s_data: got %h expected 0", tag, wr_data);
        end
        checks++;
        if (wr_prio !== '0) begin
            errors++;
            $display("FAIL %s_prio: got %0d expected 0", tag, wr_prio);
        end
        checks++;
        if (pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s_pkt_cnt: got %0d expected 0", tag, pkt_cnt);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        enable  = 1'b0;
        ready   = 1'b0;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        sys_rst = 1'b0;
        repeat (2) tick();
        check_all_zero("idle");
    endtask

    task automatic test_basic();
        enable = 1'b1;
        ready  = 1'b1;
        tick();
        checks++;
        if ({wr_vld, wr_sop, wr_eop} !== 3'b110 || wr_data !== 16'hA502 || wr_prio !== '0) begin
            errors++;
            $display("FAIL first_hdr: got vld=%0b sop=%0b eop=%0b data=%h prio=%0d expected 1 1 0 a502 0",
                     wr_vld, wr_sop, wr_eop, wr_data, wr_prio);
        end
        drive_cycle(1'b1);
        checks++;
        if (wr_data !== FIRST_PAY || wr_eop !== 1'b1) begin
            errors++;
            $display("FAIL first_pay: got data=%h eop=%0b expected data=%h eop=1", wr_data, wr_eop, FIRST_PAY);
        end
        for (int n = 0; n < 200 && m_done < 16'd5; n++) drive_cycle(1'b1);
        checks++;
        if (pkt_cnt !== 16'd5) begin
            errors++;
            $display("FAIL pkt_cnt_5: got %0d expected 5", pkt_cnt);
        end
    endtask

    task automatic test_backpressure();
        int n;
        ready = 1'b1;
        for (n = 0; n < 100; n++) begin
            if (wr_vld === 1'b1 && exp_q.size() > 0 && exp_q[0].idx == 8'd2) break;
            drive_cycle(1'b1);
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL bp_reach: got no second payload word within %0d cycles expected one", n);
        end
        repeat (3) drive_cycle(1'b0);
        for (int k = 0; k < 20; k++) drive_cycle(1'b1);
    endtask

    task automatic test_enable_drop();
        int n;
        for (n = 0; n < 100; n++) begin
            if (wr_vld === 1'b1 && exp_q.size() > 0 && exp_q[0].idx == 8'd1) break;
            drive_cycle(1'b1);
        end
        enable  = 1'b0;
        saw_eop = 1'b0;
        for (n = 0; n < 50 && !saw_eop; n++) drive_cycle(1'b1);
        checks++;
        if (!saw_eop) begin
            errors++;
            $display("FAIL drop_eop: got no eop within %0d cycles expected eop", n);
        end
        checks++;
        if (wr_vld !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_gap: got vld=%0b busy=%0b expected vld=0 busy=1", wr_vld, busy);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_vld !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL drop_idle: got vld=%0b busy=%0b expected 0 0", wr_vld, busy);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] target;
        enable = 1'b1;
        target = m_done + 16'd12;
        for (int n = 0; n < 2000 && m_done != target; n++)
            drive_cycle($urandom_range(0, 3) != 0);
        checks++;
        if (m_done != target) begin
            errors++;
            $display("FAIL random_progress: got %0d packets expected %0d", m_done, target);
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 100; n++) begin
            if (wr_vld === 1'b1 && exp_q.size() > 0 && exp_q[0].idx == 8'd1) break;
            drive_cycle($urandom_range(0, 1) != 0);
        end
        sys_rst = 1'b1;
        enable  = 1'b0;
        tick();
        check_all_zero("rst_mid");
        sys_rst = 1'b0;
        model_reset();
        enable = 1'b1;
        ready  = 1'b1;
        tick();
        checks++;
        if (wr_vld !== 1'b1 || wr_sop !== 1'b1 || wr_data !== 16'hA502 || wr_prio !== '0 || pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_restart: got vld=%0b sop=%0b data=%h prio=%0d cnt=%0d expected 1 1 a502 0 0",
                     wr_vld, wr_sop, wr_data, wr_prio, pkt_cnt);
        end
        for (int n = 0; n < 300 && m_done < 16'd3; n++) drive_cycle($urandom_range(0, 2) != 0);
        checks++;
        if (m_done != 16'd3) begin
            errors++;
            $display("FAIL rst_progress: got %0d packets expected 3", m_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_enable_drop();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_stim_gen.md
# pkt_stim_gen

Parametrised packet stimulus generator that drives the write side of the FIFO/WRR datapath (`wr_sop`/`wr_eop`/`wr_vld`/`wr_data`) under valid/ready flow control.

- Every packet starts with a header word, then carries payload words.
- Packet length and channel/priority tag rotate packet by packet, with a programmable inter-packet gap.
- It replaces the fixed one-packet hard-coded stimulus at the top level.
- It feeds `FIFO_top` and the on-chip debug probes.

## Interface
Parameters:
- `DATA_W`, 16: write data width; must be ≥16.
- `NUM_CH`, 8: number of channel/priority tags; `CH_W = $clog2(NUM_CH)`, minimum 1.
- `MIN_LEN`, 2: shortest packet in words, header included; must be ≥2.
- `MAX_LEN`, 8: longest packet in words; must satisfy `MIN_LEN ≤ MAX_LEN ≤ 255`.
- `IPG`, 1: idle cycles between an accepted eop and the next header; 0 means back-to-back.

Ports:
- `sys_clk`, in, 1: single clock.
- `sys_rst`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: run request. It is level-sensitive.
- `ready`, in, 1: downstream accepts the current word when `wr_vld & ready`.
- `wr_vld`, out, 1: word valid.
- `wr_sop`, out, 1: current word is the header.
- `wr_eop`, out, 1: current word is the last word of the packet.
- `wr_data`, out, `DATA_W`: header or payload word.
- `wr_prio`, out, `CH_W`: channel/priority tag, constant for the whole packet.
- `pkt_cnt`, out, 16: number of packets completed (eop accepted); wraps modulo 2^16.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- States: IDLE, HDR, PAY, GAP.
- IDLE → HDR when `enable` = 1.
- HDR → PAY when the header is accepted.
- PAY stays in PAY until the last word is accepted, then:
  - → GAP if `IPG` > 0;
  - → HDR if `IPG` = 0 and `enable` = 1;
  - → IDLE otherwise.
- GAP counts `IPG` cycles, then → HDR if `enable` = 1, else IDLE.
- Header word: `wr_data[15:0] = {8'hA5, len[7:0]}`. Upper bits are zero. `wr_sop` = 1.
- `len` is the total word count of the current packet.
- The payload has `len-1` words. `wr_eop` = 1 on the last payload word only.
- Payload value (default build): a `DATA_W` word counter. It starts at 0, increments per accepted payload word, and is not cleared between packets.
- Per-packet rotation, updated when eop is accepted:
  - `len` increments, wrapping from `MAX_LEN` back to `MIN_LEN`;
  - `wr_prio` increments, wrapping from `NUM_CH-1` back to 0.
- Flow control: while `wr_vld & !ready`, `wr_data`, `wr_sop`, `wr_eop` and `wr_prio` hold stable. No word is skipped or repeated.
- `enable` dropping mid-packet does not truncate the packet. It completes with eop, then the GAP state is still traversed, then IDLE.
- `pkt_cnt` increments once per accepted eop.

## Timing
- All outputs are registered.
- Reset values: `wr_vld`, `wr_sop`, `wr_eop` = 0; `wr_data`, `wr_prio` = 0; `pkt_cnt` = 0; `busy` = 0. Internal state resets to IDLE, `len` = `MIN_LEN`, payload counter = 0.
- `enable` sampled high in IDLE at edge N → header presented from edge N+1.
- With `ready` held at 1, one word is transferred per cycle.
- A packet occupies `len` cycles, followed by `IPG` cycles with `wr_vld` = 0.
- Reset mid-packet: all outputs return to reset values at the next edge, with no eop emitted. The next packet is `MIN_LEN` words with `wr_prio` = 0.
- Reset has priority over every other event.

## Configuration
- `PKT_STIM_LFSR_EN`
  - Defined: the payload is a 16-bit Fibonacci LFSR, zero-extended to `DATA_W`.
    - Polynomial x^16+x^14+x^13+x^11+1; feedback = bit0^bit2^bit3^bit5, shifted in at the MSB.
    - Seed 16'hACE1 on reset. It advances per accepted payload word only.
  - Undefined: the payload is the incrementing word counter described in Operation. No LFSR logic is present.

## Structure
- Package `pkt_stim_pkg` holds:
  - the state enum (IDLE, HDR, PAY, GAP);
  - `HDR_MARK = 8'hA5`;
  - `LFSR_SEED = 16'hACE1`.
- Sub-module `pkt_stim_lfsr` holds the LFSR register with advance-enable. It is instantiated only under `PKT_STIM_LFSR_EN`.

## Test plan
- Setup `NUM_CH`=4, `MIN_LEN`=2, `MAX_LEN`=4, `IPG`=1, `ready`=1. Release reset, `enable`=1. Expect:
  - header 16'hA502 with sop, `prio`=0, then payload 0x0000 with eop;
  - 1 idle cycle;
  - header 16'hA503 with `prio`=1, payloads 0x0001 and 0x0002.
- Wrap: after the 4-word packet the next header is 16'hA502. After `prio`=3 the next `prio` is 0. After 5 packets, `pkt_cnt`=5.
- Backpressure: `ready`=0 for 3 cycles on the second payload word. Expect `wr_data`/`wr_eop` to hold, no counter advance, and transfer to resume on the word that was held.
- `enable` dropped during payload: the packet still ends with eop, then 1 gap cycle, then IDLE with `busy`=0 and `wr_vld`=0.
- `sys_rst` pulsed mid-packet: all outputs are 0 at the next edge. After re-enable, expect header 16'hA502, `prio`=0, `pkt_cnt`=0.
- With `PKT_STIM_LFSR_EN`, defaults otherwise as in scenario 1: the first two payload words are 16'hACE1 then 16'h5670.
